// File: rtl/fifo_pkg.sv
// Shared types and helpers for the sync_fifo slice: status flags and the
// modulo-depth pointer increment.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
  } fifo_status_t;

  // Wrapping increment; depth need not be a power of two.
  function automatic int unsigned ptr_next(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Modulo-DEPTH pointer: advances on en, wraps DEPTH-1 -> 0, cleared by
// async reset or synchronous clear (clear wins over en).
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          reset_L,
  input  logic          clear,
  input  logic          en,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;

  assign w_ptr_nxt = PW'(ptr_next(32'(r_ptr), DEPTH));

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L)   r_ptr <= '0;
    else if (clear) r_ptr <= '0;
    else if (en)    r_ptr <= w_ptr_nxt;
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with valid/ready on both sides.
// Optional sticky overflow/underflow flag under SYNC_FIFO_ERR_EN.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             clear,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             err
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_wr_ptr;
  logic [PW-1:0]    w_rd_ptr;
  logic             w_wr_fire;
  logic             w_rd_fire;
  fifo_status_t     w_status;

  // Flags are pure decodes of the registered count.
  assign w_status.full        = (r_count == CW'(DEPTH));
  assign w_status.empty       = (r_count == '0);
  assign w_status.almost_full = (r_count >= CW'(AF_LEVEL));

  assign full        = w_status.full;
  assign empty       = w_status.empty;
  assign almost_full = w_status.almost_full;
  assign wr_ready    = !w_status.full;
  assign rd_valid    = !w_status.empty;
  assign count       = r_count;

  // clear suppresses any transfer presented in the same cycle.
  assign w_wr_fire = wr_valid && !w_status.full  && !clear;
  assign w_rd_fire = rd_ready && !w_status.empty && !clear;

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clock   (clock),
    .reset_L (reset_L),
    .clear   (clear),
    .en      (w_wr_fire),
    .ptr     (w_wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clock   (clock),
    .reset_L (reset_L),
    .clear   (clear),
    .en      (w_rd_fire),
    .ptr     (w_rd_ptr)
  );

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (w_wr_fire) r_mem[w_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[w_rd_ptr];

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L)   r_count <= '0;
    else if (clear) r_count <= '0;
    else begin
      case ({w_wr_fire, w_rd_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic r_err;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L)   r_err <= 1'b0;
    else if (clear) r_err <= 1'b0;
    else if ((wr_valid && w_status.full) || (rd_ready && w_status.empty))
      r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized and directed bench for sync_fifo (WIDTH=8, DEPTH=4, AF_LEVEL=3)
// against a queue-based reference model.
module tb_sync_fifo;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = 3;

  logic         clock = 1'b0;
  logic         reset_L = 1'b0;
  logic         clear = 1'b0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [W-1:0] wr_data = '0;
  logic         rd_valid;
  logic         rd_ready = 1'b0;
  logic [W-1:0] rd_data;
  logic [2:0]   count;
  logic         full, empty, almost_full, err;

  sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF)) dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .clear       (clear),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .err         (err)
  );

  always #5 clock = ~clock;

  logic [W-1:0] q[$];
  bit           m_err;
  int           checks, errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), q.size());
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == D));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
    chk("wr_ready", 32'(wr_ready), 32'(q.size() != D));
    chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
    chk("err", 32'(err), 32'(m_err));
  endtask

  // One clock: drive at negedge, model the edge, check at the next negedge.
  task automatic cyc(input bit wv, input logic [W-1:0] wd, input bit rr, input bit clr);
    bit do_w, do_r, e;
    wr_valid = wv; wr_data = wd; rd_ready = rr; clear = clr;
    do_w = wv && (q.size() < D);
    do_r = rr && (q.size() > 0);
    e = (wv && q.size() == D) || (rr && q.size() == 0);
    @(posedge clock);
    if (clr) begin
      q.delete();
      m_err = 0;
    end else begin
      if (do_r) void'(q.pop_front());
      if (do_w) q.push_back(wd);
`ifdef SYNC_FIFO_ERR_EN
      if (e) m_err = 1;
`endif
    end
    @(negedge clock);
    check_all();
  endtask

  task automatic async_reset();
    #2 reset_L = 1'b0;
    #1;
    q.delete();
    m_err = 0;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    #1 reset_L = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; m_err = 0;
    repeat (2) @(negedge clock);
    check_all();
    reset_L = 1'b1;

    // Fill to almost full, then full, then overflow attempt.
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 0);
    cyc(1, 8'h33, 0, 0);
    cyc(1, 8'h44, 0, 0);
    cyc(1, 8'h55, 0, 0);

    // Push and pop together starting from full.
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h60 + i), 1, 0);
    while (q.size() != 0) cyc(0, 8'h00, 1, 0);

    // Wrap at steady occupancy of 2.
    cyc(1, 8'hE0, 0, 0);
    cyc(1, 8'hE1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 8'(i), 1, 0);
    while (q.size() != 0) cyc(0, 8'h00, 1, 0);

    // No same-cycle fall-through into an empty FIFO.
    wr_valid = 1; wr_data = 8'hA5;
    #1 chk("no_fallthru", 32'(rd_valid), 0);
    cyc(1, 8'hA5, 0, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 0);   // underflow attempt

    // Asynchronous reset mid-operation.
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h02, 0, 0);
    cyc(1, 8'h03, 0, 0);
    async_reset();
    cyc(1, 8'h7E, 0, 0);
    cyc(1, 8'h7F, 0, 0);
    cyc(0, 8'h00, 1, 0);

    // clear with an error pending and a write in the same cycle.
    repeat (4) cyc(1, 8'hC3, 0, 0);
    cyc(1, 8'hC4, 0, 1);
    cyc(1, 8'h5A, 0, 0);

    // Random traffic with occasional clear and reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      cyc(($urandom_range(0, 3) != 0), 8'($urandom),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
